udc_cmd_sequencer: RTL and testbench

- Bus-master controller for the 8-bit up/down counter block.
- Accepts one counting job per valid/ready handshake: PLR, ULR, LLR and CCR values.
- Sequence per job: pre-checks the job, writes the four counter registers over the ncs/nwr/nrd/A1:A0 bus, optionally reads them back, issues a one-clock start pulse, waits for end-of-count, then reports a status code.
- Sits between the host/CPU logic and the counter; the top level owns the tri-state on the counter data pins.

---
 rtl/udc_cmd_sequencer_if.sv | 37 +++
 rtl/udc_cmd_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_udc_cmd_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udc_cmd_sequencer_if.sv
// Host command handshake plus the parallel bus to the 8-bit up/down counter.
// master: the sequencer side. slave: the host/counter side.
interface udc_cmd_sequencer_if;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic [7:0] cmd_plr_i;
   logic [7:0] cmd_ulr_i;
   logic [7:0] cmd_llr_i;
   logic [7:0] cmd_ccr_i;
   logic       udc_ncs_o;
   logic       udc_nwr_o;
   logic       udc_nrd_o;
   logic       udc_a1_o;
   logic       udc_a0_o;
   logic [7:0] udc_d_o;
   logic       udc_d_oe_o;
   logic [7:0] udc_d_i;
   logic       udc_start_o;
   logic       udc_err_i;
   logic       udc_ec_i;

   modport master (
      input  cmd_valid_i, cmd_plr_i, cmd_ulr_i, cmd_llr_i, cmd_ccr_i,
      input  udc_d_i, udc_err_i, udc_ec_i,
      output cmd_ready_o,
      output udc_ncs_o, udc_nwr_o, udc_nrd_o, udc_a1_o, udc_a0_o,
      output udc_d_o, udc_d_oe_o, udc_start_o
   );

   modport slave (
      output cmd_valid_i, cmd_plr_i, cmd_ulr_i, cmd_llr_i, cmd_ccr_i,
      output udc_d_i, udc_err_i, udc_ec_i,
      input  cmd_ready_o,
      input  udc_ncs_o, udc_nwr_o, udc_nrd_o, udc_a1_o, udc_a0_o,
      input  udc_d_o, udc_d_oe_o, udc_start_o
   );
endinterface

// File: rtl/udc_cmd_sequencer.sv
// Bus-master sequencer for the 8-bit up/down counter: one job per handshake,
// pre-check, program PLR/ULR/LLR/CCR, optional readback, start, wait for EC.
//
// state      | meaning
// IDLE       | ready for a job
// WR_*       | write one counter register (ncs, nwr low, data driven)
// RD_*       | read strobe, counter registers its read data
// RD_*_S     | read strobe held, sequencer samples and compares data
// CHECK      | look at the counter config-error flag
// START      | single-clock start pulse
// RUN        | counting, wait for end-of-count or timeout
// ABORT      | ncs high for one clock to force the counter idle
// DONE       | one-clock completion pulse
module udc_cmd_sequencer #(
   parameter bit          VERIFY  = 1'b1,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic                clock_i,
   input  logic                reset_i,
   udc_cmd_sequencer_if.master bus,
   input  logic                abort_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [2:0]          status_o,
   output logic [15:0]         run_cycles_o
);

   localparam logic [2:0] ST_OK       = 3'd0;
   localparam logic [2:0] ST_BADCFG   = 3'd1;
   localparam logic [2:0] ST_UDCERR   = 3'd2;
   localparam logic [2:0] ST_MISMATCH = 3'd3;
   localparam logic [2:0] ST_TIMEOUT  = 3'd4;
   localparam logic [2:0] ST_ABORTED  = 3'd5;

   // Order matters: WR_x and RD_x/RD_x_S advance by +1, RD_CCR_S+1 is CHECK.
   typedef enum logic [4:0] {
      S_IDLE, S_WR_PLR, S_WR_ULR, S_WR_LLR, S_WR_CCR,
      S_RD_PLR, S_RD_PLR_S, S_RD_ULR, S_RD_ULR_S,
      S_RD_LLR, S_RD_LLR_S, S_RD_CCR, S_RD_CCR_S,
      S_CHECK, S_START, S_RUN, S_ABORT, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  plr_q, plr_d, ulr_q, ulr_d, llr_q, llr_d, ccr_q, ccr_d;
   logic [2:0]  status_q, status_d;
   logic [15:0] run_cycles_q, run_cycles_d;
   logic [1:0]  reg_sel;
   logic [7:0]  shadow_sel;
   logic        bad_cfg;

   assign bad_cfg = (bus.cmd_ccr_i == 8'd0) || (bus.cmd_llr_i > bus.cmd_ulr_i) ||
                    (bus.cmd_plr_i > bus.cmd_ulr_i) || (bus.cmd_plr_i < bus.cmd_llr_i);

   // Counter register addressed by the current bus phase and its shadow value
   always_comb begin
      reg_sel    = 2'd0;
      shadow_sel = plr_q;
      case (state_q)
         S_WR_ULR, S_RD_ULR, S_RD_ULR_S: reg_sel = 2'd1;
         S_WR_LLR, S_RD_LLR, S_RD_LLR_S: reg_sel = 2'd2;
         S_WR_CCR, S_RD_CCR, S_RD_CCR_S: reg_sel = 2'd3;
         default:                        reg_sel = 2'd0;
      endcase
      case (reg_sel)
         2'd1:    shadow_sel = ulr_q;
         2'd2:    shadow_sel = llr_q;
         2'd3:    shadow_sel = ccr_q;
         default: shadow_sel = plr_q;
      endcase
   end

   // Next state, shadow capture, status and run-cycle counting
   always_comb begin
      state_d      = state_q;
      plr_d        = plr_q;
      ulr_d        = ulr_q;
      llr_d        = llr_q;
      ccr_d        = ccr_q;
      status_d     = status_q;
      run_cycles_d = run_cycles_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid_i) begin
               plr_d        = bus.cmd_plr_i;
               ulr_d        = bus.cmd_ulr_i;
               llr_d        = bus.cmd_llr_i;
               ccr_d        = bus.cmd_ccr_i;
               run_cycles_d = 16'd0;
               if (bad_cfg) begin
                  status_d = ST_BADCFG;
                  state_d  = S_DONE;
               end else begin
                  status_d = ST_OK;
                  state_d  = S_WR_PLR;
               end
            end
         end
         S_WR_PLR, S_WR_ULR, S_WR_LLR,
         S_RD_PLR, S_RD_ULR, S_RD_LLR, S_RD_CCR: state_d = state_t'(state_q + 5'd1);
         S_WR_CCR: state_d = VERIFY ? S_RD_PLR : S_CHECK;
         S_RD_PLR_S, S_RD_ULR_S, S_RD_LLR_S, S_RD_CCR_S: begin
            if (bus.udc_d_i != shadow_sel) begin
               status_d = ST_MISMATCH;
               state_d  = S_DONE;
            end else begin
               state_d = state_t'(state_q + 5'd1);
            end
         end
         S_CHECK: begin
            if (bus.udc_err_i) begin
               status_d = ST_UDCERR;
               state_d  = S_DONE;
            end else begin
               state_d = S_START;
            end
         end
         S_START: state_d = S_RUN;
         S_RUN: begin
            if (run_cycles_q != 16'hFFFF) run_cycles_d = run_cycles_q + 16'd1;
            if (bus.udc_ec_i) begin
               status_d = ST_OK;
               state_d  = S_DONE;
            end else if (TIMEOUT != 0 && 32'(run_cycles_d) == TIMEOUT) begin
               status_d = ST_TIMEOUT;
               state_d  = S_ABORT;
            end
         end
         S_ABORT: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Host abort wins over any same-cycle ec, err or mismatch outcome.
      if (abort_i && state_q != S_IDLE && state_q != S_DONE && state_q != S_ABORT) begin
         status_d = ST_ABORTED;
         state_d  = S_ABORT;
      end
   end

   // Bus pins decoded from state; ncs stays low from WR_PLR through RUN
   always_comb begin
      bus.udc_ncs_o   = 1'b1;
      bus.udc_nwr_o   = 1'b1;
      bus.udc_nrd_o   = 1'b1;
      bus.udc_a1_o    = 1'b0;
      bus.udc_a0_o    = 1'b0;
      bus.udc_d_o     = 8'd0;
      bus.udc_d_oe_o  = 1'b0;
      bus.udc_start_o = 1'b0;
      case (state_q)
         S_WR_PLR, S_WR_ULR, S_WR_LLR, S_WR_CCR: begin
            bus.udc_ncs_o                = 1'b0;
            bus.udc_nwr_o                = 1'b0;
            bus.udc_d_oe_o               = 1'b1;
            {bus.udc_a1_o, bus.udc_a0_o} = reg_sel;
            bus.udc_d_o                  = shadow_sel;
         end
         S_RD_PLR, S_RD_PLR_S, S_RD_ULR, S_RD_ULR_S,
         S_RD_LLR, S_RD_LLR_S, S_RD_CCR, S_RD_CCR_S: begin
            bus.udc_ncs_o                = 1'b0;
            bus.udc_nrd_o                = 1'b0;
            {bus.udc_a1_o, bus.udc_a0_o} = reg_sel;
         end
         S_CHECK, S_RUN: bus.udc_ncs_o = 1'b0;
         S_START: begin
            bus.udc_ncs_o   = 1'b0;
            bus.udc_start_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.cmd_ready_o = (state_q == S_IDLE);
   assign busy_o          = (state_q != S_IDLE);
   assign done_o          = (state_q == S_DONE);
   assign status_o        = status_q;
   assign run_cycles_o    = run_cycles_q;

   // State and shadow registers, synchronous reset
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         plr_q        <= 8'd0;
         ulr_q        <= 8'd0;
         llr_q        <= 8'd0;
         ccr_q        <= 8'd0;
         status_q     <= ST_OK;
         run_cycles_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         plr_q        <= plr_d;
         ulr_q        <= ulr_d;
         llr_q        <= llr_d;
         ccr_q        <= ccr_d;
         status_q     <= status_d;
         run_cycles_q <= run_cycles_d;
      end
   end

endmodule

// File: tb/tb_udc_cmd_sequencer.sv
// Bench for udc_cmd_sequencer: instance 0 has VERIFY=0/TIMEOUT=4096,
// instance 1 has VERIFY=1/TIMEOUT=8. Each has a small behavioural counter.
`timescale 1ns/1ps
module tb_udc_cmd_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       cmd_valid [2];
   logic [7:0] cmd_plr [2], cmd_ulr [2], cmd_llr [2], cmd_ccr [2];
   logic       abort [2], corrupt [2], ec_low [2], err_force [2];
   logic       busy [2], done [2], ready [2];
   logic [2:0] status [2];
   logic [15:0] rc [2];
   logic       ncs [2], nwr [2], nrd [2], oe [2], start [2];
   logic [1:0] addr [2];
   logic [7:0] dout [2], cnt_m [2];
   logic       run_m [2];

   for (genvar g = 0; g < 2; g++) begin : g_u
      localparam bit          VER = (g == 1);
      localparam int unsigned TO  = (g == 1) ? 8 : 4096;
      udc_cmd_sequencer_if bus();
      logic [7:0] r [4];
      logic [7:0] rd_q, cnt_q, cyc_q;
      logic       run_q, up_q, ec_raw;
      logic [1:0] a;

      assign bus.cmd_valid_i = cmd_valid[g];
      assign bus.cmd_plr_i   = cmd_plr[g];
      assign bus.cmd_ulr_i   = cmd_ulr[g];
      assign bus.cmd_llr_i   = cmd_llr[g];
      assign bus.cmd_ccr_i   = cmd_ccr[g];
      assign bus.udc_d_i     = rd_q;
      assign bus.udc_err_i   = err_force[g];
      assign a      = {bus.udc_a1_o, bus.udc_a0_o};
      assign ec_raw = run_q && up_q && (cyc_q == r[3]) && (cnt_q == r[0]);
      assign bus.udc_ec_i = ec_raw && !ec_low[g];

      assign ready[g] = bus.cmd_ready_o;
      assign ncs[g]   = bus.udc_ncs_o;
      assign nwr[g]   = bus.udc_nwr_o;
      assign nrd[g]   = bus.udc_nrd_o;
      assign oe[g]    = bus.udc_d_oe_o;
      assign start[g] = bus.udc_start_o;
      assign addr[g]  = a;
      assign dout[g]  = bus.udc_d_o;
      assign cnt_m[g] = cnt_q;
      assign run_m[g] = run_q;

      udc_cmd_sequencer #(.VERIFY(VER), .TIMEOUT(TO)) u_dut (
         .clock_i(clk), .reset_i(rst), .bus(bus), .abort_i(abort[g]),
         .busy_o(busy[g]), .done_o(done[g]), .status_o(status[g]), .run_cycles_o(rc[g]));

      // Counter model: runs PLR up to ULR, down to LLR, back up; EC at PLR after CCR turns.
      always @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < 4; i++) r[i] <= 8'd0;
            rd_q <= 8'd0; cnt_q <= 8'd0; cyc_q <= 8'd0; run_q <= 1'b0; up_q <= 1'b0;
         end else begin
            if (!bus.udc_ncs_o && !bus.udc_nwr_o && bus.udc_d_oe_o) r[a] <= bus.udc_d_o;
            if (!bus.udc_ncs_o && !bus.udc_nrd_o)
               rd_q <= (corrupt[g] && a == 2'd1) ? 8'h04 : r[a];
            if (bus.udc_ncs_o) begin
               run_q <= 1'b0; cnt_q <= 8'd0;
            end else if (bus.udc_start_o) begin
               run_q <= 1'b1; cnt_q <= r[0]; up_q <= 1'b1; cyc_q <= 8'd0;
            end else if (run_q && !ec_raw) begin
               if (up_q) begin
                  if (cnt_q >= r[1]) begin up_q <= 1'b0; cnt_q <= cnt_q - 8'd1; end
                  else cnt_q <= cnt_q + 8'd1;
               end else begin
                  if (cnt_q <= r[2]) begin up_q <= 1'b1; cnt_q <= cnt_q + 8'd1; cyc_q <= cyc_q + 8'd1; end
                  else cnt_q <= cnt_q - 8'd1;
               end
            end
         end
      end
   end

   int n_cmp = 0, n_bad = 0, n_viol = 0;
   int n_done [2], n_ncs_low [2], n_start [2];
   int trace0 [$];
   logic [9:0] wr_log [$];

   typedef struct {
      logic [7:0] p, u, l, c;
      logic [2:0] st;
      int         rcy;
   } vec_t;
   vec_t vt [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         if (done[g]) n_done[g]++;
         if (!ncs[g]) n_ncs_low[g]++;
         if (start[g]) n_start[g]++;
         if (!nwr[g] && !nrd[g]) n_viol++;
         if (oe[g] && nwr[g]) n_viol++;
      end
      if (run_m[0] && !ncs[0]) trace0.push_back(int'(cnt_m[0]));
      if (!nwr[0]) wr_log.push_back({addr[0], dout[0]});
   endtask

   task automatic chk_reset(input int g);
      check("rst_ready", 32'(ready[g]), 1);
      check("rst_busy", 32'(busy[g]), 0);
      check("rst_strobes", {29'd0, ncs[g], nwr[g], nrd[g]}, 32'h7);
      check("rst_addr_data", {22'd0, addr[g], dout[g]}, 0);
      check("rst_oe_start_done", {29'd0, oe[g], start[g], done[g]}, 0);
      check("rst_status", 32'(status[g]), 0);
      check("rst_run_cycles", 32'(rc[g]), 0);
   endtask

   // Issue one job, return the cycle (after accept) of the start pulse and of done.
   task automatic job(input int g, input logic [7:0] p, u, l, c,
                      output int st_cyc, output int dn_cyc);
      n_done[g] = 0; n_ncs_low[g] = 0; n_start[g] = 0;
      trace0.delete(); wr_log.delete();
      cmd_plr[g] = p; cmd_ulr[g] = u; cmd_llr[g] = l; cmd_ccr[g] = c;
      cmd_valid[g] = 1'b1;
      tick();
      cmd_valid[g] = 1'b0;
      st_cyc = -1;
      dn_cyc = 1;
      while (!done[g] && dn_cyc < 6000) begin
         if (start[g] && st_cyc < 0) st_cyc = dn_cyc;
         tick();
         dn_cyc++;
      end
      if (!done[g]) begin
         n_cmp++; n_bad++;
         $display("FAIL job_done_wait: no done_o within %0d clocks, expected done", dn_cyc);
      end
   endtask

   int st_c, dn_c;
   int exp_tr [9];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      for (int g = 0; g < 2; g++) begin
         cmd_valid[g] = 0; cmd_plr[g] = 0; cmd_ulr[g] = 0; cmd_llr[g] = 0; cmd_ccr[g] = 0;
         abort[g] = 0; corrupt[g] = 0; ec_low[g] = 0; err_force[g] = 0;
      end
      rst = 1'b1;
      vt[0] = '{8'd9, 8'd5, 8'd1, 8'd1, 3'd1, 0};
      vt[1] = '{8'd3, 8'd5, 8'd1, 8'd0, 3'd1, 0};
      vt[2] = '{8'd5, 8'd5, 8'd1, 8'd1, 3'd0, 9};
      vt[3] = '{8'd0, 8'd5, 8'd6, 8'd1, 3'd1, 0};
      vt[4] = '{8'd6, 8'd5, 8'd1, 8'd1, 3'd1, 0};
      vt[5] = '{8'd0, 8'd5, 8'd1, 8'd1, 3'd1, 0};
      vt[6] = '{8'd3, 8'd4, 8'd2, 8'd2, 3'd0, 9};
      vt[7] = '{8'd7, 8'd7, 8'd6, 8'd3, 3'd0, 7};
      exp_tr = '{2, 3, 4, 5, 4, 3, 2, 1, 2};
      repeat (3) tick();
      chk_reset(0);
      chk_reset(1);
      rst = 1'b0;
      tick();

      // Basic job, VERIFY=0: writes, start latency, counter trace, status/run cycles.
      job(0, 8'd2, 8'd5, 8'd1, 8'd1, st_c, dn_c);
      check("v0_start_cycle", st_c, 6);
      check("v0_start_pulses", n_start[0], 1);
      check("v0_done_cycle", dn_c, 16);
      check("v0_status", 32'(status[0]), 0);
      check("v0_run_cycles", 32'(rc[0]), 9);
      check("v0_write_count", wr_log.size(), 4);
      if (wr_log.size() == 4) begin
         check("v0_wr_plr", 32'(wr_log[0]), 32'h002);
         check("v0_wr_ulr", 32'(wr_log[1]), 32'h105);
         check("v0_wr_llr", 32'(wr_log[2]), 32'h201);
         check("v0_wr_ccr", 32'(wr_log[3]), 32'h301);
      end
      check("v0_trace_len", trace0.size(), 9);
      for (int i = 0; i < 9 && i < trace0.size(); i++) check("v0_trace", trace0[i], exp_tr[i]);
      tick();
      check("v0_done_width", n_done[0], 1);
      check("v0_ready_after", 32'(ready[0]), 1);
      check("v0_status_hold", 32'(status[0]), 0);

      // Pre-check table; each job issued on the first IDLE cycle after the previous one.
      for (int i = 0; i < 8; i++) begin
         job(0, vt[i].p, vt[i].u, vt[i].l, vt[i].c, st_c, dn_c);
         check("tbl_status", 32'(status[0]), 32'(vt[i].st));
         check("tbl_run_cycles", 32'(rc[0]), 32'(vt[i].rcy));
         check("tbl_done_cycle", dn_c, (vt[i].st == 3'd1) ? 1 : 7 + vt[i].rcy);
         if (vt[i].st == 3'd1) check("tbl_badcfg_ncs_low", n_ncs_low[0], 0);
         else check("tbl_start_cycle", st_c, 6);
         tick();
         check("tbl_ready", 32'(ready[0]), 1);
         check("tbl_status_hold", 32'(status[0]), 32'(vt[i].st));
      end

      // Counter config error seen in CHECK.
      err_force[0] = 1'b1;
      job(0, 8'd2, 8'd5, 8'd1, 8'd1, st_c, dn_c);
      err_force[0] = 1'b0;
      check("err_status", 32'(status[0]), 2);
      check("err_done_cycle", dn_c, 6);
      check("err_no_start", n_start[0], 0);
      tick();

      // Abort during the third RUN clock.
      n_done[0] = 0;
      cmd_plr[0] = 8'd2; cmd_ulr[0] = 8'd5; cmd_llr[0] = 8'd1; cmd_ccr[0] = 8'd1;
      cmd_valid[0] = 1'b1;
      tick();
      cmd_valid[0] = 1'b0;
      repeat (8) tick();
      check("abt_in_run_cnt", 32'(cnt_m[0]), 4);
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      check("abt_ncs_high", {30'd0, ncs[0], busy[0]}, 32'h3);
      check("abt_no_done_yet", 32'(done[0]), 0);
      tick();
      check("abt_done", 32'(done[0]), 1);
      check("abt_status", 32'(status[0]), 5);
      check("abt_run_cycles", 32'(rc[0]), 3);
      check("abt_counter_idle", {23'd0, run_m[0], cnt_m[0]}, 0);
      tick();

      // VERIFY=1 instance: clean readback.
      job(1, 8'd2, 8'd3, 8'd1, 8'd1, st_c, dn_c);
      check("ver_start_cycle", st_c, 14);
      check("ver_done_cycle", dn_c, 20);
      check("ver_status", 32'(status[1]), 0);
      check("ver_run_cycles", 32'(rc[1]), 5);
      tick();

      // Corrupted ULR readback.
      corrupt[1] = 1'b1;
      job(1, 8'd2, 8'd5, 8'd1, 8'd1, st_c, dn_c);
      corrupt[1] = 1'b0;
      check("mis_status", 32'(status[1]), 3);
      check("mis_done_cycle", dn_c, 9);
      check("mis_no_start", n_start[1], 0);
      tick();

      // Timeout with EC never asserted.
      ec_low[1] = 1'b1;
      job(1, 8'd2, 8'd5, 8'd1, 8'd1, st_c, dn_c);
      ec_low[1] = 1'b0;
      check("to_status", 32'(status[1]), 4);
      check("to_run_cycles", 32'(rc[1]), 8);
      check("to_done_cycle", dn_c, 24);
      check("to_ncs_low_cycles", n_ncs_low[1], 22);
      tick();

      // Reset asserted in WR_LLR.
      n_done[1] = 0;
      cmd_plr[1] = 8'd2; cmd_ulr[1] = 8'd5; cmd_llr[1] = 8'd1; cmd_ccr[1] = 8'd1;
      cmd_valid[1] = 1'b1;
      tick();
      cmd_valid[1] = 1'b0;
      tick();
      tick();
      check("rstj_in_wr_llr", {29'd0, addr[1], nwr[1]}, 32'h4);
      rst = 1'b1;
      tick();
      chk_reset(1);
      rst = 1'b0;
      repeat (5) tick();
      check("rstj_no_done", n_done[1], 0);
      check("strobe_exclusive", n_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
